// File: rtl/serial_peer_if.sv
// -----------------------------------------------------------------------------
// serial_peer_if -- parallel-side handshake bundle for serial_peer.
//
// Transmit path : tx_data / tx_valid (from user) and tx_ready (from peer).
// Receive path  : rx_data / rx_valid / rx_frame_err / rx_overrun (from peer)
//                 and rx_ack (from user).
//
// Modports
//   master : the user logic that feeds bytes in and reads bytes out.
//   slave  : the serial_peer block itself.
// -----------------------------------------------------------------------------
interface serial_peer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/serial_peer.sv
// -----------------------------------------------------------------------------
// serial_peer -- 8N1 serial peer for an SCC channel (async serial, LSB first).
//
// Ports
//   clk_14m  in   14.32 MHz master clock, single clock domain (rising edge)
//   reset    in   asynchronous, active-high reset
//   ser_rxd  in   serial line from SCC txd, idle high
//   ser_txd  out  serial line to SCC rxd, idle high (driven straight from a flop)
//   rts_n_i  in   SCC RTS, active low; low permits this peer to transmit
//   cts_n_o  out  to SCC CTS, active low; low means a byte can be accepted
//   bus      if   serial_peer_if.slave: tx/rx parallel handshakes
//
// Parameters
//   BAUD_DIV   clk_14m cycles per bit (4..65535), default 1491 = 9600 baud
//   FLOW_CTRL  1: transmitter start is gated by synchronized rts_n_i
//
// Build option
//   SERIAL_PEER_RX_FIFO_EN  defined   : 4-entry receive FIFO
//                           undefined : single holding register
// -----------------------------------------------------------------------------
module serial_peer #(
  parameter int unsigned BAUD_DIV  = 1491,
  parameter bit          FLOW_CTRL = 1'b1
) (
  input  logic          clk_14m,
  input  logic          reset,
  input  logic          ser_rxd,
  output logic          ser_txd,
  input  logic          rts_n_i,
  output logic          cts_n_o,
  serial_peer_if.slave  bus
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Reset to 1 so a held-in-reset line looks idle and
  // RTS looks deasserted. rxd_prev is one more stage used only for edge
  // detection on already-synchronized data.
  // ---------------------------------------------------------------------------
  logic rxd_s1, rxd_s2, rxd_prev;
  logic rts_s1, rts_s2;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      rts_s1   <= 1'b1;
      rts_s2   <= 1'b1;
    end else begin
      rxd_s1   <= ser_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      rts_s1   <= rts_n_i;
      rts_s2   <= rts_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_count_en, rx_bit_take, rx_done, rx_stop_bad;

  // START waits half a bit to land on the start-bit midpoint; every later
  // sample is a full bit period after the previous one.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // NOTE: each combinational process assigns a default to every output first,
  // so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:      if (rxd_prev && !rxd_s2) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;  // high = glitch
      RX_DATA:      if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rxd_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rxd_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_count_en = 1'b0;
    rx_bit_take = 1'b0;
    rx_done     = 1'b0;
    rx_stop_bad = 1'b0;
    unique case (rx_state)
      RX_START: rx_count_en = 1'b1;
      RX_DATA: begin
        rx_count_en = 1'b1;
        rx_bit_take = rx_tick;
      end
      RX_STOP: begin
        rx_count_en = 1'b1;
        rx_done     = rx_tick && rxd_s2;
        rx_stop_bad = rx_tick && !rxd_s2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      if (!rx_count_en || rx_tick) rx_cnt <= '0;
      else                         rx_cnt <= rx_cnt + 16'd1;

      if (rx_state == RX_IDLE) rx_idx <= '0;
      else if (rx_bit_take)    rx_idx <= rx_idx + 3'd1;

      if (rx_bit_take) rx_shift <= {rxd_s2, rx_shift[7:1]};  // LSB arrives first
    end
  end

  // ---------------------------------------------------------------------------
  // Receive storage. A pop in the same cycle frees a slot before the push is
  // judged, so a completion coinciding with rx_ack on full storage is kept.
  // ---------------------------------------------------------------------------
  logic       pop, push_ok, full;
  logic       rx_valid_w;
  logic [7:0] rx_data_w;
  logic       frame_err_q, overrun_q, cts_q;

  assign pop     = bus.rx_ack && rx_valid_w;
  assign push_ok = rx_done && (!full || pop);

`ifdef SERIAL_PEER_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;

  // NOTE: the storage array has no reset; only pointers and count do, and the
  // head is masked to 0 while empty, so stale contents are never visible.
  always_ff @(posedge clk_14m) begin
    if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign full       = (fifo_count == 3'd4);
  assign rx_valid_w = (fifo_count != 3'd0);
  assign rx_data_w  = rx_valid_w ? fifo_mem[rd_ptr] : 8'h00;
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_ok) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_shift;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign full       = hold_valid;
  assign rx_valid_w = hold_valid;
  assign rx_data_w  = hold_data;
`endif

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cts_q       <= 1'b1;
    end else begin
      frame_err_q <= rx_stop_bad;
      overrun_q   <= rx_done && full && !pop;
      cts_q       <= full;
    end
  end

  assign bus.rx_valid     = rx_valid_w;
  assign bus.rx_data      = rx_data_w;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_overrun   = overrun_q;
  assign cts_n_o          = cts_q;

  // ---------------------------------------------------------------------------
  // Transmitter FSM. The whole frame {stop, data, start} sits in a 10-bit
  // shift register whose bit 0 is the line, so ser_txd is a plain flop and
  // reset (all ones) forces the line high at once.
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [9:0]  tx_frame;
  logic        ready_en;
  logic        tx_tick, flow_ok;
  logic        tx_ready_w, tx_load, tx_shift_en;

  assign tx_tick = (tx_cnt == BIT_LAST);
  // RTS only gates the start of a frame; a frame in flight always completes.
  assign flow_ok = !FLOW_CTRL || !rts_s2;

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_ready_w && bus.tx_valid) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_ready_w  = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_ready_w = ready_en && flow_ok;
        tx_load    = tx_ready_w && bus.tx_valid;
      end
      default: tx_shift_en = tx_tick;
    endcase
  end

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_frame <= '1;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;  // holds tx_ready low while reset is asserted

      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 16'd1;

      if (tx_state != TX_DATA) tx_idx <= '0;
      else if (tx_tick)        tx_idx <= tx_idx + 3'd1;

      if (tx_load)          tx_frame <= {1'b1, bus.tx_data, 1'b0};
      else if (tx_shift_en) tx_frame <= {1'b1, tx_frame[9:1]};
    end
  end

  assign ser_txd      = tx_frame[0];
  assign bus.tx_ready = tx_ready_w;

endmodule

// File: tb/tb_serial_peer.sv
// -----------------------------------------------------------------------------
// tb_serial_peer -- directed bench for serial_peer with BAUD_DIV=16,
// FLOW_CTRL=1. Covers reset values, a transmitted frame bit by bit, good /
// bad-stop / glitch receive frames, storage overrun, RTS gating and reset in
// the middle of a frame.
// -----------------------------------------------------------------------------
module tb_serial_peer;
  localparam int BAUD = 16;

  logic clk_14m = 1'b0;
  logic reset   = 1'b1;
  logic ser_rxd = 1'b1;
  logic rts_n_i = 1'b0;
  logic ser_txd;
  logic cts_n_o;

  serial_peer_if bus();

  serial_peer #(.BAUD_DIV(BAUD), .FLOW_CTRL(1'b1)) dut (
    .clk_14m (clk_14m),
    .reset   (reset),
    .ser_rxd (ser_rxd),
    .ser_txd (ser_txd),
    .rts_n_i (rts_n_i),
    .cts_n_o (cts_n_o),
    .bus     (bus)
  );

  always #5 clk_14m = ~clk_14m;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Pulse / event monitors sampled on the falling edge.
  int   ferr_cycles = 0;
  int   ovr_cycles  = 0;
  int   valid_rises = 0;
  logic valid_q     = 1'b0;

  always @(negedge clk_14m) begin
    if (bus.rx_frame_err === 1'b1) ferr_cycles++;
    if (bus.rx_overrun === 1'b1)   ovr_cycles++;
    if (bus.rx_valid === 1'b1 && valid_q !== 1'b1) valid_rises++;
    valid_q = bus.rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_14m);
    #1;
  endtask

  // Drive one 8N1 frame onto ser_rxd, then 8 idle-high cycles.
  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rxd = f[i];
      cycles(BAUD);
    end
    ser_rxd = 1'b1;
    cycles(8);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    cycles(1);
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_frame;
    logic [9:0] got;
    int         bad [10];
    int         rises0, lows, wait_n;
    logic       started;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ack   = 1'b0;

    // ---- reset values ----
    #12;
    check("rst_ser_txd",      ser_txd,          16'h1);
    check("rst_cts_n_o",      cts_n_o,          16'h1);
    check("rst_tx_ready",     bus.tx_ready,     16'h0);
    check("rst_rx_valid",     bus.rx_valid,     16'h0);
    check("rst_rx_data",      bus.rx_data,      16'h00);
    check("rst_rx_frame_err", bus.rx_frame_err, 16'h0);
    check("rst_rx_overrun",   bus.rx_overrun,   16'h0);
    @(posedge clk_14m);
    #1 reset = 1'b0;
    cycles(3);
    check("post_rst_tx_ready", bus.tx_ready, 16'h1);
    check("post_rst_cts_n_o",  cts_n_o,      16'h0);

    // ---- transmit 0xA5: accept, then change tx_data ----
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    @(posedge clk_14m);            // acceptance edge
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'hFF;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) bad[k] = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk_14m);
      if (ser_txd !== exp_frame[c / 16]) bad[c / 16]++;
      if (c == 159) check("tx_ready_at_159", bus.tx_ready, 16'h0);
    end
    for (int k = 0; k < 10; k++) check($sformatf("tx_a5_bit%0d_bad_cycles", k), 16'(bad[k]), 16'h0);
    @(negedge clk_14m);
    check("tx_ready_at_160", bus.tx_ready, 16'h1);
    check("tx_idle_high",    ser_txd,      16'h1);
    cycles(1);

    // ---- receive 0x3C, then ack ----
    drive_rx(8'h3C, 1'b1);
    check("rx_3c_valid", bus.rx_valid, 16'h1);
    check("rx_3c_data",  bus.rx_data,  16'h3C);
    check("rx_3c_cts",   cts_n_o,      16'h1);
    ack();
    check("rx_3c_acked", bus.rx_valid, 16'h0);
    ack();                         // ack while empty is ignored
    check("rx_ack_empty", bus.rx_valid, 16'h0);

    // ---- bad stop bit, then good 0x55 ----
    rises0 = valid_rises;
    drive_rx(8'h81, 1'b0);
    check("ferr_pulse_cycles", 16'(ferr_cycles), 16'd1);
    check("ferr_no_valid",     bus.rx_valid,     16'h0);
    check("ferr_no_rise",      16'(valid_rises), 16'(rises0));
    drive_rx(8'h55, 1'b1);
    check("rx_55_valid", bus.rx_valid, 16'h1);
    check("rx_55_data",  bus.rx_data,  16'h55);
    ack();

    // ---- 4-cycle glitch on idle line ----
    rises0 = valid_rises;
    ser_rxd = 1'b0;
    cycles(4);
    ser_rxd = 1'b1;
    cycles(40);
    check("glitch_no_rise", 16'(valid_rises), 16'(rises0));
    check("glitch_no_ferr", 16'(ferr_cycles), 16'd1);

    // ---- overrun ----
`ifdef SERIAL_PEER_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) drive_rx(8'(i), 1'b1);
    check("ovr_pulse_cycles", 16'(ovr_cycles), 16'd1);
    check("ovr_cts_full",     cts_n_o,         16'h1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fifo_head_%0d", i), bus.rx_data, 16'(i));
      ack();
    end
    check("fifo_drained", bus.rx_valid, 16'h0);
`else
    drive_rx(8'h11, 1'b1);
    check("ovr_cts_full", cts_n_o, 16'h1);
    drive_rx(8'h22, 1'b1);
    check("ovr_pulse_cycles", 16'(ovr_cycles), 16'd1);
    check("ovr_keep_first",   bus.rx_data,     16'h11);
    check("ovr_still_valid",  bus.rx_valid,    16'h1);
    ack();
    check("ovr_acked", bus.rx_valid, 16'h0);
`endif
    cycles(2);
    check("cts_after_drain", cts_n_o, 16'h0);

    // ---- RTS flow control ----
    rts_n_i = 1'b1;
    cycles(3);
    bus.tx_data  = 8'h0F;
    bus.tx_valid = 1'b1;
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_14m);
      if (ser_txd !== 1'b1) lows++;
    end
    check("flow_held_low_cycles", 16'(lows),     16'd0);
    check("flow_held_tx_ready",   bus.tx_ready,  16'h0);
    cycles(1);
    rts_n_i = 1'b0;
    started = 1'b0;
    wait_n  = 0;
    for (int c = 1; c <= 6 && !started; c++) begin
      cycles(1);
      if (ser_txd === 1'b0) begin
        started      = 1'b1;
        wait_n       = c;
        bus.tx_valid = 1'b0;
      end
    end
    if (!started) bus.tx_valid = 1'b0;
    check("flow_started",        started,             16'h1);
    check("flow_start_within_4", (wait_n <= 4) ? 1'b1 : 1'b0, 16'h1);
    got = '1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk_14m);
      if (c == 64) rts_n_i = 1'b1;   // deassert mid-frame
      if (c % 16 == 8) got[c / 16] = ser_txd;
    end
    check("flow_frame_complete", got, {6'h0, 1'b1, 8'h0F, 1'b0});
    @(negedge clk_14m);
    check("flow_after_txd",   ser_txd,      16'h1);
    check("flow_after_ready", bus.tx_ready, 16'h0);

    // ---- reset in the middle of a frame ----
    cycles(1);
    rts_n_i = 1'b0;
    drive_rx(8'h77, 1'b1);
    check("pre_rst_rx_valid", bus.rx_valid, 16'h1);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    cycles(1);
    bus.tx_valid = 1'b0;
    cycles(20);
    check("pre_rst_txd_low", ser_txd, 16'h0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_txd_high", ser_txd,      16'h1);
    check("mid_rst_rx_valid", bus.rx_valid, 16'h0);
    check("mid_rst_cts",      cts_n_o,      16'h1);
    check("mid_rst_tx_ready", bus.tx_ready, 16'h0);
    cycles(1);
    reset = 1'b0;
    cycles(3);
    check("rel_tx_ready", bus.tx_ready, 16'h1);
    check("rel_txd_high", ser_txd,      16'h1);
    check("rel_rx_valid", bus.rx_valid, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_peer.md
SERIAL_PEER -- requirements
Module: serial_peer

Interface
REQ-001 Parameter: BAUD_DIV, 1491, clk_14m cycles per bit period (14.318 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter: FLOW_CTRL, 1, when 1 transmission is gated by rts_n_i; when 0 rts_n_i is ignored.
REQ-003 clk_14m  input  1  14.32 MHz master clock; the block has one clock, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ser_rxd  input  1  serial line from SCC txd; idle high; 8N1, LSB first.
REQ-006 ser_txd  output  1  serial line to SCC rxd; idle high; 8N1, LSB first.
REQ-007 rts_n_i  input  1  SCC RTS, active low; low permits peer transmission.
REQ-008 cts_n_o  output  1  to SCC CTS, active low; low means the peer can accept a byte.
REQ-009 tx_data  input  8  byte to send.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  transmitter can accept a byte.
REQ-012 rx_data  output  8  received byte.
REQ-013 rx_valid  output  1  rx_data holds an unread byte.
REQ-014 rx_ack  input  1  consumes the byte on rx_data.
REQ-015 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-016 rx_overrun  output  1  one-cycle pulse: a completed byte was dropped because storage was full.

Function
REQ-017 ser_rxd and rts_n_i SHALL each pass through a 2-flop synchronizer; both flops reset to 1.
REQ-018 Receiver states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-019 In IDLE, a synchronized 1->0 transition SHALL enter START; at BAUD_DIV/2 (truncated) cycles the line SHALL be resampled: low enters DATA, high returns to IDLE (glitch reject).
REQ-020 In DATA, 8 bits SHALL be sampled at BAUD_DIV-cycle intervals from the start-bit midpoint, LSB first; STOP samples one further bit period later.
REQ-021 Stop bit 1: byte SHALL be stored and the receiver returns to IDLE; stop bit 0: rx_frame_err pulses, byte discarded, enter WAIT_HIGH, which returns to IDLE on the first synchronized high sample.
REQ-022 Transmitter states SHALL be IDLE, START, DATA and STOP; tx_ready=1 only in IDLE and, when FLOW_CTRL=1, only while synchronized rts_n_i=0.
REQ-023 Handshake: byte SHALL be accepted on the cycle tx_valid and tx_ready are both 1; ser_txd goes low the next cycle; each bit lasts exactly BAUD_DIV cycles; tx_ready returns to 1 exactly 10*BAUD_DIV cycles after ser_txd went low.
REQ-024 rts_n_i deasserting mid-frame SHALL NOT abort or stretch the frame in progress.
REQ-025 tx_data SHALL be captured at acceptance; later changes to tx_data SHALL NOT affect the frame.
REQ-026 Receive storage without the FIFO SHALL be one holding register: rx_valid held at 1 until rx_ack; a completion while rx_valid=1 and rx_ack=0 drops the new byte and pulses rx_overrun.
REQ-027 A completion in the same cycle as rx_ack on full storage SHALL be accepted (the pop frees a slot first); there SHALL be no overrun in that case.
REQ-028 rx_ack while rx_valid=0 SHALL be ignored.
REQ-029 cts_n_o SHALL be registered and equal the storage-full condition of the previous cycle.

Reset
REQ-030 Reset values SHALL be: ser_txd=1, cts_n_o=1, tx_ready=0, rx_valid=0, rx_data=0, rx_frame_err=0, rx_overrun=0; both FSMs IDLE; baud counters 0.
REQ-031 Reset mid-frame SHALL force ser_txd high immediately and discard any partial TX or RX byte and all stored bytes.
REQ-032 tx_ready and cts_n_o SHALL reach their operating values no later than 3 cycles after reset deasserts.

Configuration
REQ-033 SERIAL_PEER_RX_FIFO_EN defined: receive storage SHALL be a 4-entry FIFO; rx_valid = not empty; rx_data = head entry; rx_ack pops; "full" = 4 entries.
REQ-034 SERIAL_PEER_RX_FIFO_EN undefined: the single holding register of REQ-026 SHALL be used; "full" = rx_valid.

Verification
REQ-035 BAUD_DIV=16, send 0xA5 on tx -> ser_txd low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high stop bit; tx_ready high at cycle 160.
REQ-036 Drive frame 0x3C into ser_rxd -> rx_valid=1, rx_data=0x3C; rx_ack -> rx_valid=0 the next cycle.
REQ-037 Frame with stop bit 0 -> rx_frame_err one-cycle pulse, rx_valid stays 0; next good frame 0x55 is received.
REQ-038 4-cycle low glitch on idle ser_rxd -> no reception, no error pulse.
REQ-039 FIFO off: two frames, no ack -> second dropped, rx_overrun pulse, cts_n_o=1; FIFO on: five frames -> first four are read in order and the fifth overruns.
REQ-040 FLOW_CTRL=1, rts_n_i=1 with tx_valid held -> ser_txd stays high; rts_n_i=0 -> frame starts within 4 cycles; rts_n_i=1 mid-frame -> frame completes.
